// File: rtl/user_arb_pkg.sv
// user_arb_pkg: state encoding, grant codes and error data shared by user_bus_arbiter.
package user_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} arb_state_e;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
  localparam logic [31:0] ERR_DATA_DEF = 32'hBADD_ADD0;
endpackage

// File: rtl/user_arb_timeout.sv
// user_arb_timeout: counts XFER cycles from 1 on load and flags expiry at LIMIT.
module user_arb_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam logic [15:0] LIM = 16'(LIMIT);
  logic [15:0] cnt_q, cnt_d;
  assign expire = en && cnt_q == LIM;
  always_comb cnt_d = load ? 16'd1 : (en && cnt_q != LIM) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/user_bus_arbiter.sv
// user_bus_arbiter: two-master round-robin arbiter onto one Wishbone classic slave.
// Define USER_ARB_TIMEOUT_EN to force completion of transfers the slave never acknowledges.
module user_bus_arbiter
  import user_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
`ifdef USER_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
  , parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
`endif
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        la_req_i,
  input  logic        la_we_i,
  input  logic [3:0]  la_sel_i,
  input  logic [31:0] la_adr_i,
  input  logic [31:0] la_dat_i,
  output logic        la_ack_o,
  output logic [31:0] la_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);
  arb_state_e state_q, state_d;
  logic own_q, own_d, last_q, last_d, we_q, we_d;
  logic [3:0] sel_q, sel_d;
  logic [31:0] adr_q, adr_d, wdat_q, wdat_d, rd0_q, rd0_d, rd1_q, rd1_d, rsp_dat;
  logic req0, req1, win, own_live, expire;
  assign req0 = wbs_cyc_i & wbs_stb_i;
  assign req1 = la_req_i;
  // last_q names the previous winner; a tie goes to the other master
  assign win = (req0 && req1) ? (FIXED_PRIO ? 1'b0 : ~last_q) : req1;
  assign own_live = own_q ? la_req_i : wbs_cyc_i;
`ifdef USER_ARB_TIMEOUT_EN
  logic to_q, to_d;
  user_arb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk(wb_clk_i), .rst(wb_rst_i), .load(state_q == IDLE && state_d == XFER),
    .en(state_q == XFER), .expire(expire)
  );
  assign rsp_dat = m_ack_i ? m_dat_i : ERR_DATA;
  always_comb to_d = to_q | (state_q == XFER && own_live && expire && !m_ack_i);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) to_q <= 1'b0;
    else to_q <= to_d;
  assign timeout_o = to_q;
`else
  assign expire = 1'b0;
  assign rsp_dat = m_dat_i;
  assign timeout_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    own_d = own_q;
    last_d = last_q;
    we_d = we_q;
    sel_d = sel_q;
    adr_d = adr_q;
    wdat_d = wdat_q;
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    if (state_q == IDLE && (req0 || req1)) begin
      state_d = XFER;
      own_d = win;
      last_d = win;
      we_d = win ? la_we_i : wbs_we_i;
      sel_d = win ? la_sel_i : wbs_sel_i;
      adr_d = win ? la_adr_i : wbs_adr_i;
      wdat_d = win ? la_dat_i : wbs_dat_i;
    end else if (state_q == XFER) begin
      // an abandoned request is dropped silently, even if the slave acks that cycle
      if (!own_live) state_d = IDLE;
      else if (m_ack_i || expire) begin
        state_d = RESP;
        rd0_d = own_q ? rd0_q : rsp_dat;
        rd1_d = own_q ? rsp_dat : rd1_q;
      end
    end else if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      own_q <= 1'b0;
      last_q <= 1'b1;
      we_q <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      wdat_q <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      last_q <= last_d;
      we_q <= we_d;
      sel_q <= sel_d;
      adr_q <= adr_d;
      wdat_q <= wdat_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  assign m_cyc_o = state_q == XFER;
  assign m_stb_o = state_q == XFER;
  assign m_we_o = we_q;
  assign m_sel_o = sel_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = wdat_q;
  assign grant_o = state_q == IDLE ? GNT_NONE : own_q ? GNT_M1 : GNT_M0;
  assign wbs_ack_o = state_q == RESP && !own_q;
  assign la_ack_o = state_q == RESP && own_q;
  assign wbs_dat_o = rd0_q;
  assign la_dat_o = rd1_q;
endmodule

// File: tb/tb_user_bus_arbiter.sv
// tb_user_bus_arbiter: directed and randomized checks of user_bus_arbiter against a transaction-level model.
module tb_user_bus_arbiter;
  localparam bit FP = 1'b0;
  logic clk = 1'b0, rst = 1'b1;
  logic wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0, la_req_i = 0, la_we_i = 0;
  logic [3:0] wbs_sel_i = 0, la_sel_i = 0, m_sel_o;
  logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0, la_adr_i = 0, la_dat_i = 0;
  logic wbs_ack_o, la_ack_o, m_cyc_o, m_stb_o, m_we_o, m_ack_i, timeout_o;
  logic [31:0] wbs_dat_o, la_dat_o, m_adr_o, m_dat_o, m_dat_i;
  logic [1:0] grant_o;
  int errors = 0, checks = 0, ack0_n = 0, ack1_n = 0, exp_last = 1;
  int sl_wait = 0, stb_cnt = 0;
  logic [31:0] sl_data = 0;

  always #5 clk = ~clk;

  user_bus_arbiter #(.FIXED_PRIO(FP)
`ifdef USER_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req_i), .la_we_i(la_we_i), .la_sel_i(la_sel_i), .la_adr_i(la_adr_i),
    .la_dat_i(la_dat_i), .la_ack_o(la_ack_o), .la_dat_o(la_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always @(negedge clk) begin
    if (wbs_ack_o) ack0_n++;
    if (la_ack_o) ack1_n++;
  end

  // slave model: acks sl_wait cycles after strobe first seen; sl_wait < 0 means never
  initial begin
    m_ack_i = 1'b0;
    m_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      m_ack_i = 1'b0;
      if (m_cyc_o && m_stb_o) begin
        stb_cnt++;
        if (sl_wait >= 0 && stb_cnt == sl_wait + 1) begin m_ack_i = 1'b1; m_dat_i = sl_data; end
      end else stb_cnt = 0;
    end
  end

  task automatic drv(input int m, input logic on, input logic we, input logic [3:0] sel,
                     input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      wbs_cyc_i = on; wbs_stb_i = on; wbs_we_i = we; wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    end else begin
      la_req_i = on; la_we_i = we; la_sel_i = sel; la_adr_i = adr; la_dat_i = dat;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    idle(2);
    rst = 1'b0;
    exp_last = 1;
  endtask

  task automatic wait_ack(input int budget, output int who, output logic [31:0] d, output int cyc,
                          output logic [1:0] g, output logic [31:0] adr, output logic [31:0] wd,
                          output logic we, output logic [3:0] sel);
    who = -1; d = '0; cyc = 0; g = '0; adr = '0; wd = '0; we = 1'b0; sel = '0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (m_stb_o) begin g = grant_o; adr = m_adr_o; wd = m_dat_o; we = m_we_o; sel = m_sel_o; end
      if (wbs_ack_o) begin who = 0; d = wbs_dat_o; return; end
      if (la_ack_o) begin who = 1; d = la_dat_o; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++; if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %b%b want 00", m_cyc_o, m_stb_o); end
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant_o); end
    checks++; if ({wbs_ack_o, la_ack_o, timeout_o, m_we_o} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {wbs_ack_o, la_ack_o, timeout_o, m_we_o}); end
    checks++; if (wbs_dat_o !== 32'h0 || la_dat_o !== 32'h0 || m_adr_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h %h %h want 0", wbs_dat_o, la_dat_o, m_adr_o); end
    rst = 1'b0;
    exp_last = 1;
  endtask

  task automatic test_m0_read();
    int who, cyc, a0, a1; logic [31:0] d, adr, wd; logic [1:0] g; logic we; logic [3:0] sel;
    a0 = ack0_n; a1 = ack1_n; sl_wait = 2; sl_data = 32'h1234_5678;
    @(negedge clk);
    drv(0, 1, 0, 4'hF, 32'h3000_0004, 32'h0);
    wait_ack(20, who, d, cyc, g, adr, wd, we, sel);
    drv(0, 0, 0, 0, 0, 0);
    checks++; if (who !== 0) begin errors++; $display("FAIL rd_who: got %0d want 0", who); end
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h want 12345678", d); end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", cyc); end
    checks++; if (g !== 2'b01 || adr !== 32'h3000_0004 || we !== 1'b0) begin errors++; $display("FAIL rd_bus: got g=%b adr=%h we=%b want 01 30000004 0", g, adr, we); end
    @(negedge clk);
    checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b want 0", wbs_ack_o); end
    checks++; if (wbs_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_hold: got %h want 12345678", wbs_dat_o); end
    checks++; if (ack0_n - a0 !== 1 || ack1_n !== a1) begin errors++; $display("FAIL rd_ackcnt: got %0d/%0d want 1/0", ack0_n - a0, ack1_n - a1); end
    exp_last = 0;
  endtask

  task automatic test_m1_write();
    int who, cyc, a0; logic [31:0] d, adr, wd; logic [1:0] g; logic we; logic [3:0] sel;
    a0 = ack0_n; sl_wait = 1; sl_data = 32'h0000_00EE;
    @(negedge clk);
    drv(1, 1, 1, 4'b0011, 32'h3000_0010, 32'hA5A5_A5A5);
    wait_ack(20, who, d, cyc, g, adr, wd, we, sel);
    drv(1, 0, 0, 0, 0, 0);
    checks++; if (who !== 1) begin errors++; $display("FAIL wr_who: got %0d want 1", who); end
    checks++; if (we !== 1'b1 || sel !== 4'b0011) begin errors++; $display("FAIL wr_we_sel: got %b %b want 1 0011", we, sel); end
    checks++; if (adr !== 32'h3000_0010 || wd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wr_adr_dat: got %h %h want 30000010 a5a5a5a5", adr, wd); end
    checks++; if (cyc !== 3 || g !== 2'b10) begin errors++; $display("FAIL wr_lat_grant: got %0d %b want 3 10", cyc, g); end
    checks++; if (d !== 32'h0000_00EE) begin errors++; $display("FAIL wr_capture: got %h want 000000ee", d); end
    idle(1);
    checks++; if (ack0_n !== a0) begin errors++; $display("FAIL wr_no_m0_ack: got %0d want %0d", ack0_n, a0); end
    exp_last = 1;
  endtask

  task automatic test_arbitration();
    int who, cyc, exp; logic [31:0] d, adr, wd, ed; logic [1:0] g; logic we; logic [3:0] sel;
    do_reset();
    drv(0, 1, 0, 4'hF, 32'h3000_0100, 32'h0);
    drv(1, 1, 0, 4'hF, 32'h3000_0200, 32'h0);
    for (int k = 0; k < 4; k++) begin
      sl_wait = $urandom_range(0, 2); sl_data = $urandom; ed = sl_data;
      exp = FP ? 0 : 1 - exp_last;
      wait_ack(20, who, d, cyc, g, adr, wd, we, sel);
      checks++; if (who !== exp || g !== (exp == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL arb_order%0d: got %0d/%b want %0d", k, who, g, exp); end
      checks++; if (d !== ed || adr !== (exp == 0 ? 32'h3000_0100 : 32'h3000_0200)) begin errors++; $display("FAIL arb_data%0d: got %h %h want %h", k, d, adr, ed); end
      exp_last = exp;
    end
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    idle(2);
  endtask

  task automatic test_reset_mid();
    int who, cyc, a0; logic [31:0] d, adr, wd; logic [1:0] g; logic we; logic [3:0] sel;
    a0 = ack0_n; sl_wait = -1;
    @(negedge clk);
    drv(0, 1, 0, 4'hF, 32'h3000_0020, 32'h0);
    idle(2);
    checks++; if (m_cyc_o !== 1'b1) begin errors++; $display("FAIL rm_pre: got %b want 1", m_cyc_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_cyc_o !== 1'b0 || grant_o !== 2'b00) begin errors++; $display("FAIL rm_async: got %b %b want 0 00", m_cyc_o, grant_o); end
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    exp_last = 1;
    idle(3);
    checks++; if (ack0_n !== a0) begin errors++; $display("FAIL rm_no_ack: got %0d want %0d", ack0_n, a0); end
    sl_wait = 0; sl_data = 32'hCAFE_0005;
    drv(1, 1, 0, 4'hF, 32'h3000_0024, 32'h0);
    wait_ack(20, who, d, cyc, g, adr, wd, we, sel);
    drv(1, 0, 0, 0, 0, 0);
    checks++; if (who !== 1 || d !== 32'hCAFE_0005) begin errors++; $display("FAIL rm_after: got %0d %h want 1 cafe0005", who, d); end
    exp_last = 1;
  endtask

  task automatic test_drop();
    int who, cyc, a0; logic [31:0] d, adr, wd; logic [1:0] g; logic we; logic [3:0] sel;
    a0 = ack0_n; sl_wait = -1;
    @(negedge clk);
    drv(0, 1, 0, 4'hF, 32'h3000_0028, 32'h0);
    @(negedge clk);
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL drop_grant0: got %b want 01", grant_o); end
    drv(1, 1, 1, 4'h3, 32'h3000_0030, 32'h0BAD_F00D);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    sl_wait = 0; sl_data = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if (m_cyc_o !== 1'b0) begin errors++; $display("FAIL drop_cyc: got %b want 0", m_cyc_o); end
    wait_ack(20, who, d, cyc, g, adr, wd, we, sel);
    drv(1, 0, 0, 0, 0, 0);
    checks++; if (who !== 1 || g !== 2'b10 || adr !== 32'h3000_0030 || d !== 32'h5555_AAAA) begin errors++; $display("FAIL drop_next: got %0d %b %h %h want 1 10 30000030 5555aaaa", who, g, adr, d); end
    idle(1);
    checks++; if (ack0_n !== a0) begin errors++; $display("FAIL drop_no_ack: got %0d want %0d", ack0_n, a0); end
    exp_last = 1;
  endtask

  task automatic test_random();
    int who, cyc, pat; int order[$]; logic [31:0] d, adr, wd, ed; logic [1:0] g; logic we; logic [3:0] sel;
    logic r_we[2]; logic [3:0] r_sel[2]; logic [31:0] r_adr[2], r_dat[2];
    for (int r = 0; r < 30; r++) begin
      pat = $urandom_range(1, 3);
      order.delete();
      for (int m = 0; m < 2; m++) begin
        r_we[m] = 1'($urandom); r_sel[m] = 4'($urandom);
        r_adr[m] = 32'h3000_0000 | ($urandom & 32'h0000_FFFC); r_dat[m] = $urandom;
      end
      if (pat == 3) begin
        order.push_back(FP ? 0 : 1 - exp_last);
        order.push_back(1 - order[0]);
      end else order.push_back(pat - 1);
      sl_wait = $urandom_range(0, 3); sl_data = $urandom;
      @(negedge clk);
      if ((pat & 1) != 0) drv(0, 1, r_we[0], r_sel[0], r_adr[0], r_dat[0]);
      if ((pat & 2) != 0) drv(1, 1, r_we[1], r_sel[1], r_adr[1], r_dat[1]);
      foreach (order[k]) begin
        ed = sl_data;
        wait_ack(20, who, d, cyc, g, adr, wd, we, sel);
        checks++; if (who !== order[k] || g !== (order[k] == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rnd_owner r%0d: got %0d/%b want %0d", r, who, g, order[k]); end
        checks++; if (adr !== r_adr[order[k]] || wd !== r_dat[order[k]] || we !== r_we[order[k]] || sel !== r_sel[order[k]]) begin errors++; $display("FAIL rnd_bus r%0d: got %h %h %b %h want %h %h %b %h", r, adr, wd, we, sel, r_adr[order[k]], r_dat[order[k]], r_we[order[k]], r_sel[order[k]]); end
        checks++; if (d !== ed) begin errors++; $display("FAIL rnd_data r%0d: got %h want %h", r, d, ed); end
        exp_last = order[k];
        drv(order[k], 0, 0, 0, 0, 0);
        sl_wait = $urandom_range(0, 3); sl_data = $urandom;
      end
      idle(1);
    end
  endtask

`ifdef USER_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int who, cyc; logic [31:0] d, adr, wd; logic [1:0] g; logic we; logic [3:0] sel;
    sl_wait = -1;
    @(negedge clk);
    drv(0, 1, 0, 4'hF, 32'h3000_0040, 32'h0);
    wait_ack(30, who, d, cyc, g, adr, wd, we, sel);
    drv(0, 0, 0, 0, 0, 0);
    checks++; if (who !== 0 || cyc !== 9) begin errors++; $display("FAIL to_lat: got %0d %0d want 0 9", who, cyc); end
    checks++; if (d !== 32'hBADD_ADD0 || timeout_o !== 1'b1) begin errors++; $display("FAIL to_err: got %h %b want baddadd0 1", d, timeout_o); end
    sl_wait = 0; sl_data = 32'h1111_2222;
    drv(1, 1, 0, 4'hF, 32'h3000_0044, 32'h0);
    wait_ack(20, who, d, cyc, g, adr, wd, we, sel);
    drv(1, 0, 0, 0, 0, 0);
    checks++; if (timeout_o !== 1'b1 || d !== 32'h1111_2222) begin errors++; $display("FAIL to_sticky: got %b %h want 1 11112222", timeout_o, d); end
    do_reset();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_o); end
    sl_wait = 7; sl_data = 32'h7777_0001;
    drv(0, 1, 0, 4'hF, 32'h3000_0048, 32'h0);
    wait_ack(30, who, d, cyc, g, adr, wd, we, sel);
    drv(0, 0, 0, 0, 0, 0);
    checks++; if (who !== 0 || cyc !== 9 || d !== 32'h7777_0001 || timeout_o !== 1'b0) begin errors++; $display("FAIL to_race: got %0d %0d %h %b want 0 9 77770001 0", who, cyc, d, timeout_o); end
    exp_last = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_arbitration();
    test_reset_mid();
    test_drop();
    test_random();
`ifdef USER_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
